// File: rtl/picomem_sram_pkg.sv
// Shared PicoMem definitions: controller state encoding and byte-lane count.
package picomem_sram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/picomem_sram_lane.sv
// One byte lane of the PicoMem SRAM: single-port, read-first, registered
// output. The array carries no reset so it maps onto FPGA block RAM.
module picomem_sram_lane #(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  wre,
  input  logic [ADDR_WIDTH-1:0] ad,
  input  logic [7:0]            din,
  output logic [7:0]            dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] dout_q;

  // Read-first port: the old word is captured before the optional write.
  always_ff @(posedge clk) begin
    if (ce) begin
      dout_q <= mem[ad];
      if (wre) begin
        mem[ad] <= din;
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/picomem_sram_param.sv
// PicoMem SRAM: 2**ADDR_WIDTH x 32-bit word memory with per-byte strobes,
// optional zero-fill after reset, and a two-cycle valid/ready handshake.
module picomem_sram_param
  import picomem_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_s_valid,
  input  logic [31:0] mem_s_addr,
  input  logic [31:0] mem_s_wdata,
  input  logic [3:0]  mem_s_wstrb,
  output logic        mem_s_ready,
  output logic [31:0] mem_s_rdata,
  output logic        init_done
);

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rvalid_q, rvalid_d;

  logic                    ram_ce;
  logic                    ram_clear;
  logic [ADDR_WIDTH-1:0]   ram_ad;
  logic [NUM_LANES*8-1:0]  lane_dout;
  logic                    unused_addr_bits;

  // Byte-offset and above-depth address bits alias silently.
  assign unused_addr_bits = ^{mem_s_addr[31:ADDR_WIDTH+2], mem_s_addr[1:0]};

  // Controller state, clear counter and output qualifiers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Next-state logic and RAM port control.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    rvalid_d    = rvalid_q;
    ram_ce      = 1'b0;
    ram_clear   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        ram_ce    = 1'b1;
        ram_clear = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        init_done_d = 1'b1;
        if (mem_s_valid) begin
          ram_ce   = 1'b1;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_ad = ram_clear ? clr_cnt_q : mem_s_addr[ADDR_WIDTH+1:2];

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    picomem_sram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk  (clk),
      .ce   (ram_ce),
      .wre  (ram_ce & (ram_clear | mem_s_wstrb[n])),
      .ad   (ram_ad),
      .din  (ram_clear ? 8'h00 : mem_s_wdata[8*n +: 8]),
      .dout (lane_dout[8*n +: 8])
    );
  end

  assign mem_s_ready = (state_q == ST_RESP);
  assign init_done   = init_done_q;
  // Lane output registers have no reset and also capture stale words while
  // clearing; rdata stays zero until a real access has completed.
  assign mem_s_rdata = rvalid_q ? lane_dout : '0;

endmodule
